// File: rtl/capture_dump_if.sv
// Bus between the capture-dump sequencer, the capture RAM read port and the UART transmitter.
//   dump/start_addr : dump request and oldest-sample address
//   raddr/rdata     : RAM read port (1-clk registered read latency)
//   tx_data/trmt/tx_done : UART byte handshake
//   dumping/dump_done    : dump status
// slave is the sequencer's view; master is the view of whatever surrounds it.
interface capture_dump_if #(
  parameter int unsigned LOG2 = 9
) ();
  logic            dump;
  logic [LOG2-1:0] start_addr;
  logic [LOG2-1:0] raddr;
  logic [7:0]      rdata;
  logic [7:0]      tx_data;
  logic            trmt;
  logic            tx_done;
  logic            dumping;
  logic            dump_done;

  modport master (
    output dump, start_addr, rdata, tx_done,
    input  raddr, tx_data, trmt, dumping, dump_done
  );

  modport slave (
    input  dump, start_addr, rdata, tx_done,
    output raddr, tx_data, trmt, dumping, dump_done
  );
endinterface

// File: rtl/capture_dump.sv
// Read-side sequencer for one channel's circular capture RAM. On a dump request
// it reads all ENTRIES samples oldest first, starting at start_addr and wrapping
// at ENTRIES-1 -> 0, and hands each byte to the UART with a trmt/tx_done handshake.
// Ports:
//   clk   : system clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : capture_dump_if.slave (dump, start_addr, raddr, rdata, tx_data,
//           trmt, tx_done, dumping, dump_done); all outputs registered
module capture_dump #(
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned LOG2    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  capture_dump_if.slave bus
);

  localparam int unsigned AW = LOG2;
  localparam int unsigned DW = 8;
  localparam logic [AW-1:0] LAST_ADDR = AW'(ENTRIES - 1);
  // One bit wider so ENTRIES == 2**LOG2 still compares correctly
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(ENTRIES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LAT  = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic [1:0]    state_q,     state_d;
  logic [AW-1:0] raddr_q,     raddr_d;
  logic [AW-1:0] cnt_q,       cnt_d;
  logic [DW-1:0] tx_data_q,   tx_data_d;
  logic          trmt_q,      trmt_d;
  logic          dumping_q,   dumping_d;
  logic          dump_done_q, dump_done_d;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    raddr_d     = raddr_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;
    dumping_d   = dumping_q;
    dump_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.dump) begin
          // Out-of-range start address falls back to the bottom of the RAM
          raddr_d   = ({1'b0, bus.start_addr} >= DEPTH) ? '0 : bus.start_addr;
          cnt_d     = '0;
          dumping_d = 1'b1;
          state_d   = S_LAT;
        end
      end

      // RAM registers raddr on this edge
      S_LAT: state_d = S_LOAD;

      S_LOAD: begin
        tx_data_d = bus.rdata;
        trmt_d    = 1'b1;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        // A tx_done arriving together with trmt cannot belong to this byte yet
        if (bus.tx_done && !trmt_q) begin
          if (cnt_q == LAST_ADDR) begin
            dump_done_d = 1'b1;
            dumping_d   = 1'b0;
            state_d     = S_IDLE;
          end else begin
            cnt_d   = cnt_q + AW'(1);
            raddr_d = (raddr_q == LAST_ADDR) ? '0 : raddr_q + AW'(1);
            state_d = S_LAT;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      raddr_q     <= '0;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
      dumping_q   <= 1'b0;
      dump_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      trmt_q      <= trmt_d;
      dumping_q   <= dumping_d;
      dump_done_q <= dump_done_d;
    end
  end

  assign bus.raddr     = raddr_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.trmt      = trmt_q;
  assign bus.dumping   = dumping_q;
  assign bus.dump_done = dump_done_q;

endmodule

// File: tb/tb_capture_dump.sv
// Directed bench for capture_dump: an 8-entry instance (wrap, re-dump, stall,
// mid-dump reset) and a 384-entry instance (linear dump, out-of-range start,
// tx_done coincident with trmt).
`timescale 1ns/1ps
module tb_capture_dump;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  capture_dump_if #(.LOG2(3)) a_if ();
  capture_dump_if #(.LOG2(9)) b_if ();

  capture_dump #(.ENTRIES(8), .LOG2(3)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  capture_dump #(.ENTRIES(384), .LOG2(9)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  // Capture RAMs with 1-clk registered read: A holds A0+i, B holds i[7:0]
  always @(posedge clk) a_if.rdata <= 8'hA0 + 8'(a_if.raddr);
  always @(posedge clk) b_if.rdata <= 8'(b_if.raddr);

  // UART models: tx_done pulse a fixed delay after trmt
  int a_delay = 10;
  bit a_hold  = 1'b0;
  int b_delay = 3;
  bit b_early = 1'b0;

  initial begin : uart_a
    a_if.tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (a_if.trmt === 1'b1) begin
        repeat (a_delay) begin @(posedge clk); #1; end
        while (a_hold) begin @(posedge clk); #1; end
        a_if.tx_done = 1'b1;
        @(posedge clk); #1;
        a_if.tx_done = 1'b0;
      end
    end
  end

  initial begin : uart_b
    b_if.tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (b_if.trmt === 1'b1) begin
        if (b_early) b_if.tx_done = 1'b1;
        repeat (b_delay) begin @(posedge clk); #1; b_if.tx_done = 1'b0; end
        b_if.tx_done = 1'b1;
        @(posedge clk); #1;
        b_if.tx_done = 1'b0;
      end
    end
  end

  // Monitor A: byte log, handshake rule, tx_done->trmt spacing
  logic [7:0] a_seq[$];
  int a_trmt = 0, a_done = 0, a_viol = 0, a_gapbad = 0;
  initial begin : mon_a
    int cyc = 0;
    int last_done = -1;
    bit owed = 1'b0;
    logic [7:0] held = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n || a_if.dumping !== 1'b1) begin owed = 1'b0; last_done = -1; end
      if (a_if.trmt === 1'b1) begin
        if (owed) a_viol++;
        if (last_done >= 0 && cyc - last_done != 3) a_gapbad++;
        owed = 1'b1;
        held = a_if.tx_data;
        a_seq.push_back(a_if.tx_data);
        a_trmt++;
      end else begin
        if (owed && a_if.tx_data !== held) a_viol++;
        if (owed && a_if.tx_done === 1'b1) begin owed = 1'b0; last_done = cyc; end
      end
      if (a_if.dump_done === 1'b1) a_done++;
      cyc++;
    end
  end

  // Monitor B: byte n of a dump starting at 0 must be n[7:0]; raddr stays < 384
  int b_trmt = 0, b_done = 0, b_viol = 0, b_bad = 0, b_rbad = 0, b_gapbad = 0;
  initial begin : mon_b
    int cyc = 0;
    int last_done = -1;
    int idx = 0;
    bit owed = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || b_if.dumping !== 1'b1) begin owed = 1'b0; last_done = -1; idx = 0; end
      if (b_if.raddr > 9'd383) b_rbad++;
      if (b_if.trmt === 1'b1) begin
        if (owed) b_viol++;
        if (last_done >= 0 && cyc - last_done != 3) b_gapbad++;
        if (b_if.tx_data !== 8'(idx)) b_bad++;
        idx++;
        owed = 1'b1;
        b_trmt++;
      end else if (owed && b_if.tx_done === 1'b1) begin
        owed = 1'b0;
        last_done = cyc;
      end
      if (b_if.dump_done === 1'b1) b_done++;
      cyc++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic dump_a(input logic [2:0] sa);
    a_if.start_addr = sa;
    a_if.dump = 1'b1;
    step();
    a_if.dump = 1'b0;
  endtask

  task automatic dump_b(input logic [8:0] sa);
    b_if.start_addr = sa;
    b_if.dump = 1'b1;
    step();
    b_if.dump = 1'b0;
  endtask

  task automatic wait_a_done(input string tag);
    int n = 0;
    while (a_if.dump_done !== 1'b1 && n < 2000) begin step(); n++; end
    check({tag, "_done_seen"}, 32'(n < 2000), 32'd1);
    check({tag, "_dumping_falls"}, 32'(a_if.dumping), 32'd0);
  endtask

  task automatic wait_b_done(input string tag);
    int n = 0;
    while (b_if.dump_done !== 1'b1 && n < 10000) begin step(); n++; end
    check({tag, "_done_seen"}, 32'(n < 10000), 32'd1);
    check({tag, "_dumping_falls"}, 32'(b_if.dumping), 32'd0);
  endtask

  task automatic wait_a_trmt(input int target);
    int n = 0;
    while (a_trmt < target && n < 2000) begin step(); n++; end
    check("a_trmt_reached", 32'(n < 2000), 32'd1);
  endtask

  task automatic check_a_seq(input string tag, input int base, input logic [7:0] exp[8]);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(a_seq[base + i]), 32'(exp[i]));
  endtask

  initial begin : main
    logic [7:0] seq5[8] = '{8'hA5, 8'hA6, 8'hA7, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    logic [7:0] seq2[8] = '{8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA0, 8'hA1};
    logic [7:0] held;
    int base, d0, bad;

    a_if.dump = 1'b0; a_if.start_addr = '0;
    b_if.dump = 1'b0; b_if.start_addr = '0;

    // Reset state
    step(); step();
    check("rst_a_raddr",     32'(a_if.raddr),     32'd0);
    check("rst_a_tx_data",   32'(a_if.tx_data),   32'd0);
    check("rst_a_trmt",      32'(a_if.trmt),      32'd0);
    check("rst_a_dumping",   32'(a_if.dumping),   32'd0);
    check("rst_a_dump_done", 32'(a_if.dump_done), 32'd0);
    check("rst_b_raddr",     32'(b_if.raddr),     32'd0);
    rst_n = 1'b1;
    step();

    // Wrapped dump from address 5, with dump->trmt latency
    base = a_trmt; d0 = a_done;
    dump_a(3'd5);
    check("t1_dumping_e0", 32'(a_if.dumping), 32'd1);
    check("t1_raddr_e0",   32'(a_if.raddr),   32'd5);
    check("t1_trmt_e0",    32'(a_if.trmt),    32'd0);
    step();
    check("t1_trmt_e1",    32'(a_if.trmt),    32'd0);
    step();
    check("t1_trmt_e2",    32'(a_if.trmt),    32'd1);
    check("t1_txdata_e2",  32'(a_if.tx_data), 32'hA5);
    wait_a_done("t1");
    check("t1_trmt_count", 32'(a_trmt - base), 32'd8);
    check("t1_done_count", 32'(a_done - d0),   32'd1);
    check_a_seq("t1", base, seq5);

    // Back-to-back dump; second dump request at byte 3 must be ignored
    base = a_trmt; d0 = a_done;
    dump_a(3'd5);
    wait_a_trmt(base + 3);
    a_if.start_addr = 3'd2;
    a_if.dump = 1'b1;
    step();
    a_if.dump = 1'b0;
    wait_a_done("t3");
    check("t3_trmt_count", 32'(a_trmt - base), 32'd8);
    check("t3_done_count", 32'(a_done - d0),   32'd1);
    check_a_seq("t3", base, seq5);

    // UART stalls for 1000 clocks in WAIT
    a_hold = 1'b1;
    base = a_trmt;
    dump_a(3'd5);
    wait_a_trmt(base + 1);
    held = a_if.tx_data;
    check("t4_held_byte", 32'(held), 32'hA5);
    bad = 0;
    repeat (1000) begin
      step();
      if (a_if.trmt !== 1'b0 || a_if.tx_data !== held) bad++;
    end
    check("t4_stall_quiet", 32'(bad), 32'd0);
    check("t4_stall_count", 32'(a_trmt - base), 32'd1);
    a_hold = 1'b0;
    wait_a_done("t4");
    check("t4_trmt_count", 32'(a_trmt - base), 32'd8);
    check_a_seq("t4", base, seq5);

    // Asynchronous reset after byte 4, then a replay
    base = a_trmt; d0 = a_done;
    dump_a(3'd2);
    wait_a_trmt(base + 4);
    check("t5_pre_trmt",  32'(a_if.trmt),  32'd1);
    check("t5_pre_raddr", 32'(a_if.raddr), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_trmt",    32'(a_if.trmt),    32'd0);
    check("t5_rst_dumping", 32'(a_if.dumping), 32'd0);
    check("t5_rst_raddr",   32'(a_if.raddr),   32'd0);
    step(); step(); step();
    check("t5_no_done", 32'(a_done - d0), 32'd0);
    rst_n = 1'b1;
    repeat (20) step();
    base = a_trmt; d0 = a_done;
    dump_a(3'd2);
    wait_a_done("t5");
    check("t5_trmt_count", 32'(a_trmt - base), 32'd8);
    check("t5_done_count", 32'(a_done - d0),   32'd1);
    check_a_seq("t5", base, seq2);
    check("a_handshake", 32'(a_viol),   32'd0);
    check("a_done_gap",  32'(a_gapbad), 32'd0);

    // Full 384-entry linear dump from 0
    base = b_trmt; d0 = b_done;
    dump_b(9'd0);
    wait_b_done("t2");
    check("t2_trmt_count", 32'(b_trmt - base), 32'd384);
    check("t2_done_count", 32'(b_done - d0),   32'd1);
    check("t2_bytes",      32'(b_bad),         32'd0);

    // Out-of-range start and tx_done coincident with trmt
    b_early = 1'b1;
    base = b_trmt; d0 = b_done;
    dump_b(9'd400);
    check("t6_raddr_e0",  32'(b_if.raddr),   32'd0);
    step();
    check("t6_trmt_e1",   32'(b_if.trmt),    32'd0);
    step();
    check("t6_trmt_e2",   32'(b_if.trmt),    32'd1);
    check("t6_txdata_e2", 32'(b_if.tx_data), 32'h00);
    wait_b_done("t6");
    check("t6_trmt_count", 32'(b_trmt - base), 32'd384);
    check("t6_done_count", 32'(b_done - d0),   32'd1);
    check("t6_bytes",      32'(b_bad),         32'd0);
    check("b_raddr_range", 32'(b_rbad),        32'd0);
    check("b_handshake",   32'(b_viol),        32'd0);
    check("b_done_gap",    32'(b_gapbad),      32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
